// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Drives a NUM_INPUTS-input combinational function through every input
// vector in ascending order, samples its output after SETTLE_CYCLES wait
// cycles, and assembles the full truth table together with its ones-count.
//
// Optional build feature: define TT_CHECK_EN to add the expected_tt / match /
// mismatch_idx ports, which compare the swept table against a reference
// captured when the sweep starts.
module tt_sweep_ctrl #(
  parameter int NUM_INPUTS    = 7,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic [NUM_INPUTS-1:0]        x_out,
  input  logic                         f_in,
  output logic                         busy,
  output logic                         done,
  output logic                         result_valid,
  output logic [(1<<NUM_INPUTS)-1:0]   tt,
  output logic [NUM_INPUTS:0]          ones_count
`ifdef TT_CHECK_EN
  ,
  input  logic [(1<<NUM_INPUTS)-1:0]   expected_tt,
  output logic                         match,
  output logic [NUM_INPUTS-1:0]        mismatch_idx
`endif
);

  localparam int TT_W  = 1 << NUM_INPUTS;
  // The settle counter must be able to hold SETTLE_CYCLES itself because it
  // increments on every SETTLE cycle, including the last one.
  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [NUM_INPUTS-1:0] LAST_IDX = '1;
  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [NUM_INPUTS-1:0] index_reg;
  logic [NUM_INPUTS-1:0] x_out_reg;
  logic [CNT_W-1:0]      settle_cnt_reg;
  logic                  busy_reg;
  logic                  result_valid_reg;
  logic [TT_W-1:0]       tt_reg;
  logic [NUM_INPUTS:0]   ones_count_reg;

  // Decoded control strobes from the output process.
  logic accept;       // start taken in IDLE
  logic settle_step;  // one SETTLE cycle elapsing
  logic sample_step;  // f_in captured this cycle
  logic abort_hit;    // abort cancelling an active sweep
  logic finish;       // DONE cycle
  logic done_comb;

  logic settle_last;
  logic index_last;
  logic [TT_W-1:0] bit_sel;

  assign settle_last = (settle_cnt_reg == SETTLE_LAST);
  assign index_last  = (index_reg == LAST_IDX);

  // One-hot decode of the sweep index selects which table bit captures f_in.
  for (genvar gi = 0; gi < TT_W; gi++) begin : g_bit_sel
    assign bit_sel[gi] = (index_reg == NUM_INPUTS'(gi));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort always wins over start and over progress.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = NO_SETTLE ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (settle_last) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (index_last) begin
          state_next = DONE;
        end else begin
          state_next = NO_SETTLE ? SAMPLE : SETTLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: done pulse plus the datapath control strobes.
  always_comb begin
    accept      = 1'b0;
    settle_step = 1'b0;
    sample_step = 1'b0;
    abort_hit   = 1'b0;
    finish      = 1'b0;
    done_comb   = 1'b0;
    case (state_reg)
      IDLE: begin
        accept = start && !abort;
      end
      SETTLE: begin
        settle_step = !abort;
        abort_hit   = abort;
      end
      SAMPLE: begin
        sample_step = !abort;
        abort_hit   = abort;
      end
      DONE: begin
        finish    = 1'b1;
        done_comb = 1'b1;
      end
      default: begin
        accept = 1'b0;
      end
    endcase
  end

  // Sweep index, driven vector and settle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index_reg      <= '0;
      x_out_reg      <= '0;
      settle_cnt_reg <= '0;
    end else if (accept) begin
      index_reg      <= '0;
      x_out_reg      <= '0;
      settle_cnt_reg <= '0;
    end else if (abort_hit) begin
      x_out_reg <= '0;
    end else if (settle_step) begin
      settle_cnt_reg <= settle_cnt_reg + CNT_W'(1);
    end else if (sample_step && !index_last) begin
      index_reg      <= index_reg + NUM_INPUTS'(1);
      x_out_reg      <= index_reg + NUM_INPUTS'(1);
      settle_cnt_reg <= '0;
    end
  end

  // Truth table and ones-count accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt_reg         <= '0;
      ones_count_reg <= '0;
    end else if (accept) begin
      tt_reg         <= '0;
      ones_count_reg <= '0;
    end else if (sample_step) begin
      tt_reg         <= (tt_reg & ~bit_sel) | (bit_sel & {TT_W{f_in}});
      ones_count_reg <= ones_count_reg + (NUM_INPUTS + 1)'(f_in);
    end
  end

  // Handshake flags: busy spans the sweep, result_valid marks a completed table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
    end else if (accept) begin
      busy_reg         <= 1'b1;
      result_valid_reg <= 1'b0;
    end else if (abort_hit) begin
      busy_reg <= 1'b0;
    end else if (finish) begin
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b1;
    end
  end

  assign x_out        = x_out_reg;
  assign busy         = busy_reg;
  assign done         = done_comb;
  assign result_valid = result_valid_reg;
  assign tt           = tt_reg;
  assign ones_count   = ones_count_reg;

`ifdef TT_CHECK_EN
  logic [TT_W-1:0]       exp_tt_reg;
  logic                  mismatch_seen_reg;
  logic                  match_reg;
  logic [NUM_INPUTS-1:0] mismatch_idx_reg;
  logic                  exp_bit;

  assign exp_bit = exp_tt_reg[index_reg];

  // Reference comparison: remember only the first mismatching index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_tt_reg        <= '0;
      mismatch_seen_reg <= 1'b0;
      match_reg         <= 1'b0;
      mismatch_idx_reg  <= '0;
    end else if (accept) begin
      exp_tt_reg        <= expected_tt;
      mismatch_seen_reg <= 1'b0;
      match_reg         <= 1'b0;
      mismatch_idx_reg  <= '0;
    end else begin
      if (sample_step && (f_in != exp_bit) && !mismatch_seen_reg) begin
        mismatch_idx_reg  <= index_reg;
        mismatch_seen_reg <= 1'b1;
      end
      if (finish) begin
        match_reg <= !mismatch_seen_reg;
      end
    end
  end

  assign match        = match_reg;
  assign mismatch_idx = mismatch_idx_reg;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: three instances (SETTLE_CYCLES = 1, 0, 3) share a
// clock; each sweep pushes its expected table, ones-count and latency onto a
// scoreboard that is popped when the DUT pulses done.
module tb_tt_sweep_ctrl;

  localparam int NI   = 7;
  localparam int TW   = 1 << NI;
  localparam int NDUT = 3;
  localparam logic [TW-1:0] GOLDEN = 128'hfeeaeae8eeeaea80fea8a888e8a8a880;

  // Function models driven onto f_in.
  localparam int M_X0    = 0;
  localparam int M_GOLD  = 1;
  localparam int M_ONE   = 2;
  localparam int M_ZERO  = 3;

  typedef struct {
    logic [TW-1:0] tt;
    logic [NI:0]   ones;
    int            lat;
    logic          match;
    logic [NI-1:0] midx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start        [NDUT];
  logic          abort        [NDUT];
  logic          f_in         [NDUT];
  logic          busy         [NDUT];
  logic          done         [NDUT];
  logic          result_valid [NDUT];
  logic [NI-1:0] x_out        [NDUT];
  logic [TW-1:0] tt           [NDUT];
  logic [NI:0]   ones_count   [NDUT];
  int            mode         [NDUT];
`ifdef TT_CHECK_EN
  logic [TW-1:0] expected_tt  [NDUT];
  logic          match        [NDUT];
  logic [NI-1:0] mismatch_idx [NDUT];
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic logic model_bit(input int m, input logic [NI-1:0] x);
    logic [TW-1:0] g;
    g = GOLDEN;
    case (m)
      M_X0:    return x[0];
      M_GOLD:  return g[x];
      M_ONE:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected tables taken straight from the function definitions.
  function automatic logic [TW-1:0] expected_table(input int m);
    case (m)
      M_X0:    return {32{4'hA}};
      M_GOLD:  return GOLDEN;
      M_ONE:   return '1;
      default: return '0;
    endcase
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    assign f_in[gi] = model_bit(mode[gi], x_out[gi]);
    tt_sweep_ctrl #(
      .NUM_INPUTS   (NI),
      .SETTLE_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start[gi]),
      .abort        (abort[gi]),
      .x_out        (x_out[gi]),
      .f_in         (f_in[gi]),
      .busy         (busy[gi]),
      .done         (done[gi]),
      .result_valid (result_valid[gi]),
      .tt           (tt[gi]),
      .ones_count   (ones_count[gi])
`ifdef TT_CHECK_EN
      ,
      .expected_tt  (expected_tt[gi]),
      .match        (match[gi]),
      .mismatch_idx (mismatch_idx[gi])
`endif
    );
  end

  task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full sweep on instance k with function model m; etab is the
  // reference table handed to the optional checker.
  task automatic run_sweep(input int k, input int m, input logic [TW-1:0] etab,
                           input bit abort_in_done);
    exp_t e;
    exp_t got_e;
    int   cnt;
    bit   seen;
    bit   found;
    @(negedge clk);
    mode[k]  = m;
    e.tt     = expected_table(m);
    e.ones   = (NI + 1)'($countones(e.tt));
    e.lat    = 1 + TW * (settle_of(k) + 1);
    e.match  = (etab === e.tt);
    e.midx   = '0;
    found    = 1'b0;
    for (int i = 0; i < TW; i++) begin
      if (!found && (etab[i] !== e.tt[i])) begin
        e.midx = NI'(i);
        found  = 1'b1;
      end
    end
`ifdef TT_CHECK_EN
    expected_tt[k] = etab;
`endif
    sb.push_back(e);
    start[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[k] = 1'b0;
    cnt  = 1;
    check("busy_after_accept", busy[k], 1'b1);
    check("rv_cleared_on_accept", result_valid[k], 1'b0);
    seen = 1'b0;
    while (cnt <= e.lat + 20) begin
      if (done[k]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cnt++;
    end
    got_e = sb.pop_front();
    if (!seen) begin
      check("done_timeout", 1'b0, 1'b1);
    end else begin
      check("done_latency", cnt, got_e.lat);
      check("busy_in_done", busy[k], 1'b1);
      if (abort_in_done) abort[k] = 1'b1;
      @(negedge clk);
      abort[k] = 1'b0;
      check("done_one_cycle", done[k], 1'b0);
      check("busy_after_done", busy[k], 1'b0);
      check("result_valid", result_valid[k], 1'b1);
      check("tt", tt[k], got_e.tt);
      check("ones_count", ones_count[k], got_e.ones);
`ifdef TT_CHECK_EN
      check("match", match[k], got_e.match);
      check("mismatch_idx", mismatch_idx[k], got_e.midx);
`endif
    end
    $display("sweep dut%0d settle=%0d mode=%0d: latency %0d tt=%h ones=%0d",
             k, settle_of(k), m, cnt, tt[k], ones_count[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cnt;
    bit  seen;
    logic [TW-1:0] flipped;

    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      start[k] = 1'b0;
      abort[k] = 1'b0;
      mode[k]  = M_ZERO;
`ifdef TT_CHECK_EN
      expected_tt[k] = '0;
`endif
    end

    // Reset, then idle with no start: everything stays zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        check("idle_outputs", {x_out[k], busy[k], done[k], result_valid[k], ones_count[k]}, '0);
        check("idle_tt", tt[k], '0);
      end
    end
    $display("reset/idle: 10 cycles observed on %0d instances", NDUT);

    // Main sweeps.
    run_sweep(0, M_X0,   expected_table(M_X0),   1'b0);
    run_sweep(0, M_GOLD, GOLDEN,                 1'b0);
    run_sweep(1, M_ONE,  expected_table(M_ONE),  1'b0);
    run_sweep(1, M_ZERO, expected_table(M_ZERO), 1'b0);
    run_sweep(2, M_ONE,  expected_table(M_ONE),  1'b0);
    run_sweep(2, M_ZERO, expected_table(M_ZERO), 1'b0);

    // Abort mid-sweep with a redundant start along the way.
    @(negedge clk);
    mode[0]  = M_X0;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    cnt = 1;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      start[0] = (cnt == 10);
      if (cnt == 12) check("start_while_busy_ignored", x_out[0], 7'd5);
    end
    start[0] = 1'b0;
    check("x_out_before_abort", x_out[0], 7'd19);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("busy_after_abort", busy[0], 1'b0);
    check("x_out_after_abort", x_out[0], '0);
    check("rv_after_abort", result_valid[0], 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done[0] || result_valid[0] || busy[0]) seen = 1'b1;
    end
    check("quiet_after_abort", seen, 1'b0);
    $display("abort dut0 at cycle 40: busy=%0d rv=%0d", busy[0], result_valid[0]);

    // Start and abort together in IDLE: abort wins.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("start_with_abort_busy", busy[0], 1'b0);
    @(negedge clk);
    check("start_with_abort_x", x_out[0], '0);
    $display("start+abort dut0: busy=%0d", busy[0]);

    // Fresh start after abort; abort during DONE must not cancel reporting.
    run_sweep(0, M_GOLD, GOLDEN, 1'b1);

    // Reset during a sweep discards partial results.
    @(negedge clk);
    mode[0]  = M_X0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_busy", busy[0], 1'b0);
    check("reset_mid_tt", tt[0], '0);
    check("reset_mid_ones", ones_count[0], '0);
    check("reset_mid_x", x_out[0], '0);
    rst_n = 1'b1;
    $display("reset mid-sweep dut0: tt=%h", tt[0]);

`ifdef TT_CHECK_EN
    flipped = GOLDEN;
    flipped[37] = ~flipped[37];
    run_sweep(0, M_GOLD, flipped, 1'b0);
    run_sweep(0, M_GOLD, GOLDEN,  1'b0);
`else
    flipped = '0;
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
